sram_bank_dump: RTL and testbench
=================================

// Module: sram_bank_dump
// PURPOSE
//  Parametrised single-port RAM bank for subsurf working buffers (vertex/face/result).
//  Core port: byte-enable writes, fixed-latency reads. Adds a built-in dump engine that
//  streams a programmable address window out over a valid/ready interface. The bench or
//  host drains result buffers with it instead of a one-shot file-dump strobe.
// PARAMETERS
//  DATA_W    32  word width; multiple of 8
//  ADDR_W    11  address width; depth = 2**ADDR_W words
//  READ_LAT  1   core read latency in cycles; legal values 1 or 2
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous active-low reset
//  en           in   1           core access enable
//  we           in   DATA_W/8    byte write enables; 0 with en=1 means read
//  addr         in   ADDR_W      core address
//  din          in   DATA_W      core write data
//  dout         out  DATA_W      core read data
//  dump_start   in   1           1-cycle pulse; latches dump_base and dump_len
//  dump_base    in   ADDR_W      first word to stream
//  dump_len     in   ADDR_W+1    number of words; 0..2**ADDR_W
//  dump_busy    out  1           dump engine active
//  dump_valid   out  1           dump_data/dump_addr valid
//  dump_ready   in   1           consumer accepts the beat
//  dump_data    out  DATA_W      streamed word
//  dump_addr    out  ADDR_W      address of streamed word
//  dump_done    out  1           1-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset: dout=0, dump_busy=0, dump_valid=0, dump_data=0, dump_addr=0, dump_done=0,
//   FSM=IDLE. Memory array is not cleared and retains its contents through reset.
//  Core write: en=1 and we!=0 updates byte i when we[i]=1 at the clock edge; dout holds.
//  Core read: en=1 and we==0 gives mem[addr] on dout READ_LAT cycles later; dout holds
//   until the next read. Read-during-write is not possible on one port.
//  FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
//   IDLE: on dump_start, latch ptr=dump_base and cnt=dump_len.
//    If cnt==0, go to DONE; otherwise set dump_busy=1 and go to ISSUE.
//   ISSUE: if en=0, read mem[ptr] internally and go to WAIT. If en=1, the core port has
//    priority and the FSM stalls in ISSUE.
//   WAIT: after READ_LAT cycles, load dump_data/dump_addr, set dump_valid=1, go to HOLD.
//   HOLD: dump_data and dump_addr stay stable while dump_valid=1 and dump_ready=0.
//    On the valid&ready handshake: ptr+=1 (wraps mod 2**ADDR_W), cnt-=1.
//    If cnt becomes 0, go to DONE; otherwise go to ISSUE.
//    dump_valid drops in the cycle after acceptance.
//   DONE: dump_done=1 for exactly one cycle, dump_busy=0, return to IDLE.
//  Throughput: one beat per READ_LAT+2 cycles with no stall. One read is outstanding at
//   most.
//  dump_start while dump_busy=1 is ignored, with no re-latch.
//  Core writes during a dump are allowed. A beat reflects memory contents at its ISSUE
//   cycle.
//  dump_len=2**ADDR_W streams the full bank starting at dump_base, with wrap-around.
//  rst_n asserted mid-dump aborts immediately: no dump_done; all outputs take reset values.
// TESTING
//  1. Write 0xDEADBEEF to addr 5 with we=4'hF, then write addr 5 with we=4'b0010 and
//     din=0x00001100. Read addr 5 -> dout=0xDEAD11EF exactly READ_LAT cycles after the
//     read request.
//  2. Fill mem[i]=i. Dump base=10, len=4 with dump_ready=1 -> beats with addr/data
//     10,11,12,13, then dump_done one cycle after the last handshake.
//  3. Same dump with dump_ready toggling 1-0-0-1 -> every beat is held stable while
//     stalled. Data is neither lost nor duplicated. Exactly 4 handshakes occur.
//  4. Dump base=2046, len=4 with ADDR_W=11 -> beat addresses 2046, 2047, 0, 1.
//     len=0 -> dump_done one cycle after dump_start, no beats, dump_busy stays 0.
//  5. Hold en=1 for 20 cycles during a dump -> no dump issue occurs while en=1.
//     Core reads return correct data. The dump resumes and completes. A second
//     dump_start while busy is ignored.
//  6. Assert rst_n=0 after 2 of 8 beats -> all outputs 0 and no dump_done.
//     Memory keeps its contents. A new dump reproduces the pre-reset data.

Source files
------------

// File: rtl/sram_bank_dump.sv
// Single-port RAM bank with byte-enable writes, fixed-latency reads and a dump engine
// that streams an address window out over a valid/ready interface.
module sram_bank_dump #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W/8-1:0] we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_done
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   CntOne = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PtrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StHold, StDone} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   cnt_q;
    logic              buf_full_q;
    logic [DATA_W-1:0] dump_buf_q;

    logic              core_wr, core_rd, dump_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_core, pipe_dump;

    // The core port owns the array whenever en=1; the dump engine only reads in idle slots.
    assign core_wr  = en && (we != '0);
    assign core_rd  = en && (we == '0);
    assign dump_rd  = (state_q == StIssue) && !en;
    assign mem_addr = en ? addr : ptr_q;
    assign rdata    = mem[mem_addr];

    always_ff @(posedge clk) begin
        if (core_wr) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (we[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
            end
        end
    end

    // Tagged read pipeline: each result is routed to the core or the dump buffer.
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] stage_q;
            logic              stage_core_q, stage_dump_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q      <= '0;
                    stage_core_q <= 1'b0;
                    stage_dump_q <= 1'b0;
                end else begin
                    stage_core_q <= core_rd;
                    stage_dump_q <= dump_rd;
                    if (core_rd || dump_rd) stage_q <= rdata;
                end
            end

            assign pipe_data = stage_q;
            assign pipe_core = stage_core_q;
            assign pipe_dump = stage_dump_q;
        end else begin : g_lat1
            assign pipe_data = rdata;
            assign pipe_core = core_rd;
            assign pipe_dump = dump_rd;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (pipe_core) begin
            dout <= pipe_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            buf_full_q <= 1'b0;
            dump_buf_q <= '0;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_done  <= 1'b0;
        end else begin
            if (pipe_dump) begin
                dump_buf_q <= pipe_data;
                buf_full_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (dump_start) begin
                        ptr_q <= dump_base;
                        cnt_q <= dump_len;
                        if (dump_len == '0) begin
                            dump_done <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            dump_busy <= 1'b1;
                            state_q   <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (!en) state_q <= StWait;
                end
                StWait: begin
                    if (buf_full_q) begin
                        buf_full_q <= 1'b0;
                        dump_data  <= dump_buf_q;
                        dump_addr  <= ptr_q;
                        dump_valid <= 1'b1;
                        state_q    <= StHold;
                    end
                end
                StHold: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        ptr_q      <= ptr_q + PtrOne;
                        cnt_q      <= cnt_q - CntOne;
                        if (cnt_q == CntOne) begin
                            dump_busy <= 1'b0;
                            dump_done <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                end
                StDone: begin
                    dump_done <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bank_dump.sv
// Self-checking bench for sram_bank_dump: core port checks plus a scoreboard of dump beats.
module tb_sram_bank_dump;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned READ_LAT = 1;
    localparam int unsigned DEPTH    = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [3:0]        we = '0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout;
    logic              dump_start = 1'b0;
    logic [ADDR_W-1:0] dump_base = '0;
    logic [ADDR_W:0]   dump_len = '0;
    logic              dump_busy, dump_valid, dump_done;
    logic              dump_ready = 1'b1;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_addr;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_count = 0;
    int done_cnt = 0;
    bit zero_len = 1'b0;
    bit ready_mode = 1'b0;

    logic [DATA_W-1:0]        model [DEPTH];
    logic [ADDR_W+DATA_W-1:0] sb [$];
    logic [DATA_W-1:0]        rd_sb [$];

    sram_bank_dump #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .dump_start (dump_start),
        .dump_base  (dump_base),
        .dump_len   (dump_len),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_addr  (dump_addr),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [3:0] w);
        en = 1'b1; we = w; addr = a; din = d;
        tick();
        en = 1'b0; we = '0;
        for (int i = 0; i < 4; i++) if (w[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
    endtask

    task automatic core_read(input logic [ADDR_W-1:0] a);
        en = 1'b1; we = '0; addr = a;
        rd_sb.push_back(model[a]);
        tick();
        en = 1'b0;
        repeat (READ_LAT - 1) tick();
        check("core_read", dout, rd_sb.pop_front());
    endtask

    task automatic start_dump(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
        dump_base = base; dump_len = len; dump_start = 1'b1;
        for (int i = 0; i < int'(len); i++)
            sb.push_back({base + ADDR_W'(i), model[base + ADDR_W'(i)]});
        zero_len = (len == '0);
        tick();
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!dump_done && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", dump_done, 1);
        tick();
        check("busy_after_done", dump_busy, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    // Consumer ready: constant 1, or the repeating 1-0-0-1 pattern.
    initial begin
        int k = 0;
        logic [3:0] pat = 4'b1001;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                dump_ready = pat[k % 4];
                k++;
            end else begin
                dump_ready = 1'b1;
            end
        end
    end

    // Beat monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        logic [ADDR_W+DATA_W-1:0] held, exp_beat;
        bit stall_prev, hs_last_prev;
        stall_prev = 1'b0;
        hs_last_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                hs_last_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", dump_valid, 1);
                    check("hold_beat", {dump_addr, dump_data}, held);
                end
                if (dump_done) begin
                    done_cnt++;
                    check("done_timing", hs_last_prev || zero_len, 1);
                    zero_len = 1'b0;
                end
                hs_last_prev = 1'b0;
                if (dump_valid && dump_ready) begin
                    hs_count++;
                    check("beat_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        exp_beat = sb.pop_front();
                        check("beat", {dump_addr, dump_data}, exp_beat);
                        hs_last_prev = (sb.size() == 0);
                    end
                end
                stall_prev = dump_valid && !dump_ready;
                held = {dump_addr, dump_data};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, d0, n;

        repeat (3) tick();
        check("rst_dout", dout, 0);
        check("rst_dump_data", dump_data, 0);
        check("rst_ctrl", {dump_addr, dump_busy, dump_valid, dump_done}, 0);
        rst_n = 1'b1;
        tick();

        // Byte-enable merge
        core_write(5, 32'hDEADBEEF, 4'hF);
        core_write(5, 32'h00001100, 4'b0010);
        check("dout_held_over_writes", dout, 0);
        core_read(5);
        check("merge_literal", dout, 32'hDEAD11EF);

        for (int i = 0; i < int'(DEPTH); i++) core_write(ADDR_W'(i), DATA_W'(i), 4'hF);

        // Plain window, then the same window under back-pressure
        start_dump(10, 4);
        wait_done(50);
        ready_mode = 1'b1;
        h0 = hs_count;
        start_dump(10, 4);
        wait_done(100);
        check("stall_handshakes", hs_count - h0, 4);
        ready_mode = 1'b0;
        tick();

        // Wrap-around and empty window
        start_dump(11'd2046, 4);
        wait_done(50);
        h0 = hs_count;
        start_dump(0, 0);
        check("zl_done", dump_done, 1);
        check("zl_busy", dump_busy, 0);
        tick();
        check("zl_done_drop", dump_done, 0);
        check("zl_busy_low", dump_busy, 0);
        check("zl_no_beats", hs_count - h0, 0);

        // Core port holds off the dump; a second start while busy must be ignored
        h0 = hs_count;
        d0 = done_cnt;
        start_dump(200, 8);
        for (int i = 0; i < 20; i++) begin
            en = 1'b1; we = '0; addr = ADDR_W'(300 + i);
            rd_sb.push_back(model[300 + i]);
            if (i == 5) begin
                dump_base = 0; dump_len = 3; dump_start = 1'b1;
            end else begin
                dump_start = 1'b0;
            end
            tick();
            check("stall_read", dout, rd_sb.pop_front());
            check("stall_no_valid", dump_valid, 0);
            check("stall_busy", dump_busy, 1);
        end
        en = 1'b0;
        dump_start = 1'b0;
        check("stall_no_issue", hs_count - h0, 0);
        wait_done(100);
        check("stall_one_done", done_cnt - d0, 1);

        // Abort mid-dump with reset
        h0 = hs_count;
        start_dump(400, 8);
        n = 0;
        while (hs_count - h0 < 2 && n < 100) begin
            tick();
            n++;
        end
        check("abort_two_beats", hs_count - h0, 2);
        d0 = done_cnt;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_dout", dout, 0);
        check("abort_dump_data", dump_data, 0);
        check("abort_ctrl", {dump_addr, dump_busy, dump_valid, dump_done}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", {dump_busy, dump_valid}, 0);
        start_dump(400, 8);
        wait_done(100);
        core_read(405);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
